// File: rtl/atcaxi2tluh500_pkg.sv
// Shared definitions for the AXI-to-TL-UH bridge.
// Holds the TileLink source-ID count and the source-ID type. The allocator,
// the A-channel request path and the D-channel response path all use them.
package atcaxi2tluh500_pkg;

    // Number of TileLink source IDs the bridge can keep outstanding.
    localparam int SRCID_N = 8;

    // Width of a binary source ID.
    localparam int SRCID_W = $clog2(SRCID_N);

    // Binary source-ID type used on the A and D channels.
    typedef logic [SRCID_W-1:0] srcid_t;

endpackage

// File: rtl/atcaxi2tluh500_bin2onehot.sv
// Binary-to-one-hot decoder with enable.
// Ports:
//   en     in  1 : decode enable; when low the output is all zeros
//   idx    in  W : binary index
//   onehot out N : bit idx set when en is high and idx < N, else all zeros
// An index of N or more decodes to all zeros. This matters when N is not a
// power of two.
module atcaxi2tluh500_bin2onehot #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         en,
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    // Compare the index against every legal position.
    always_comb begin
        onehot = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            onehot[k] = en && (idx == W'(k));
        end
    end

endmodule

// File: rtl/atcaxi2tluh500_srcid_alloc.sv
// Source-ID allocator for the AXI-to-TL-UH bridge.
// Tracks which source IDs are outstanding. It offers a free ID in round-robin
// order for each new A-channel request, and releases the ID when its
// D-channel response retires.
// Ports:
//   aclk        in  1   : clock, rising edge
//   areset      in  1   : synchronous active-high reset
//   alloc_avail out 1   : a free ID exists and the block is not in reset
//   alloc_id    out W   : ID taken if alloc_en is asserted this cycle
//   alloc_en    in  1   : consume alloc_id
//   free_en     in  1   : release free_id
//   free_id     in  W   : ID being released
//   busy        out N   : occupancy vector (registered)
//   cnt         out W+1 : number of outstanding IDs (registered)
//   err         out 1   : sticky protocol error (registered, cleared by reset)
module atcaxi2tluh500_srcid_alloc
    import atcaxi2tluh500_pkg::*;
#(
    parameter  int N = SRCID_N,
    localparam int W = $clog2(N)
) (
    input  logic         aclk,
    input  logic         areset,
    output logic         alloc_avail,
    output logic [W-1:0] alloc_id,
    input  logic         alloc_en,
    input  logic         free_en,
    input  logic [W-1:0] free_id,
    output logic [N-1:0] busy,
    output logic [W:0]   cnt,
    output logic         err
);

    // Round-robin search for the first zero in occ, starting at start.
    // Returns {found, index}. start is always below N, so one subtraction
    // wraps the probe position.
    function automatic logic [W:0] find_free(input logic [N-1:0] occ,
                                             input logic [W-1:0] start);
        logic         found;
        logic [W-1:0] id;
        int           k;
        found = 1'b0;
        id    = {W{1'b0}};
        for (int j = 0; j < N; j++) begin
            k = (int'(start) + j >= N) ? (int'(start) + j - N) : (int'(start) + j);
            if (!found && !occ[k]) begin
                found = 1'b1;
                id    = W'(k);
            end
        end
        return {found, id};
    endfunction

    logic [N-1:0] busy_r;
    logic [W-1:0] ptr_r;
    logic [W:0]   cnt_r;
    logic         err_r;

    logic [N-1:0] busy_nxt_s;
    logic [W-1:0] ptr_nxt_s;
    logic [W:0]   cnt_nxt_s;
    logic         err_nxt_s;

    logic         found_s;
    logic [W-1:0] pick_s;
    logic         free_in_range_s;
    logic         free_hit_s;
    logic         alloc_ok_s;
    logic         free_ok_s;
    logic [N-1:0] set_mask_s;
    logic [N-1:0] clr_mask_s;

    // Select a candidate ID from registered state only.
    always_comb begin
        {found_s, pick_s} = find_free(busy_r, ptr_r);
    end

    // Validate the release request: the ID must be in range and outstanding.
    // A free of the ID being offered this cycle is a double free, because
    // that ID is idle by construction.
    always_comb begin
        free_in_range_s = ({1'b0, free_id} < (W+1)'(N));
        free_hit_s      = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (free_id == W'(k)) begin
                free_hit_s = busy_r[k];
            end else begin
                free_hit_s = free_hit_s;
            end
        end
    end

    assign alloc_ok_s = alloc_en && found_s;
    assign free_ok_s  = free_en && free_in_range_s && free_hit_s;

    // Set-mask decoder for the allocated ID.
    atcaxi2tluh500_bin2onehot #(.N(N)) u_set_dec (
        .en     (alloc_ok_s),
        .idx    (pick_s),
        .onehot (set_mask_s)
    );

    // Clear-mask decoder for the released ID.
    atcaxi2tluh500_bin2onehot #(.N(N)) u_clr_dec (
        .en     (free_ok_s),
        .idx    (free_id),
        .onehot (clr_mask_s)
    );

    // Next-state computation for occupancy, pointer, count and error flag.
    // A valid alloc and a valid free always name different IDs, so the
    // set and clear masks never overlap.
    always_comb begin
        busy_nxt_s = (busy_r | set_mask_s) & ~clr_mask_s;
        err_nxt_s  = err_r
                   | (alloc_en && !found_s)
                   | (free_en && !free_ok_s);
        if (alloc_ok_s) begin
            ptr_nxt_s = (pick_s == W'(N - 1)) ? {W{1'b0}} : (pick_s + W'(1));
        end else begin
            ptr_nxt_s = ptr_r;
        end
        case ({alloc_ok_s, free_ok_s})
            2'b10:   cnt_nxt_s = cnt_r + (W+1)'(1);
            2'b01:   cnt_nxt_s = cnt_r - (W+1)'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // State registers. A reset drops all outstanding IDs and ignores any
    // request that arrives in the same cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            busy_r <= {N{1'b0}};
            ptr_r  <= {W{1'b0}};
            cnt_r  <= {(W+1){1'b0}};
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            ptr_r  <= ptr_nxt_s;
            cnt_r  <= cnt_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    // Offered ID and availability. These are forced to zero when nothing is
    // free, and availability is also forced low while in reset.
    always_comb begin
        if (found_s) begin
            alloc_id = pick_s;
        end else begin
            alloc_id = {W{1'b0}};
        end
        alloc_avail = found_s && !areset;
    end

    assign busy = busy_r;
    assign cnt  = cnt_r;
    assign err  = err_r;

endmodule

// File: tb/tb_atcaxi2tluh500_srcid_alloc.sv
// Directed bench for the source-ID allocator: an N=8 instance and an N=5 instance.
module tb_atcaxi2tluh500_srcid_alloc;

    logic       clk;
    logic       areset;

    // N = 8 instance
    logic       a_avail;
    logic [2:0] a_id;
    logic       a_alloc_en;
    logic       a_free_en;
    logic [2:0] a_free_id;
    logic [7:0] a_busy;
    logic [3:0] a_cnt;
    logic       a_err;

    // N = 5 instance
    logic       b_avail;
    logic [2:0] b_id;
    logic       b_alloc_en;
    logic       b_free_en;
    logic [2:0] b_free_id;
    logic [4:0] b_busy;
    logic [3:0] b_cnt;
    logic       b_err;

    int n_cmp;
    int n_bad;

    atcaxi2tluh500_srcid_alloc #(.N(8)) dut_a (
        .aclk        (clk),
        .areset      (areset),
        .alloc_avail (a_avail),
        .alloc_id    (a_id),
        .alloc_en    (a_alloc_en),
        .free_en     (a_free_en),
        .free_id     (a_free_id),
        .busy        (a_busy),
        .cnt         (a_cnt),
        .err         (a_err)
    );

    atcaxi2tluh500_srcid_alloc #(.N(5)) dut_b (
        .aclk        (clk),
        .areset      (areset),
        .alloc_avail (b_avail),
        .alloc_id    (b_id),
        .alloc_en    (b_alloc_en),
        .free_en     (b_free_en),
        .free_id     (b_free_id),
        .busy        (b_busy),
        .cnt         (b_cnt),
        .err         (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset     = 1'b1;
        a_alloc_en = 1'b0;
        a_free_en  = 1'b0;
        b_alloc_en = 1'b0;
        b_free_en  = 1'b0;
        step();
        areset = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        areset     = 1'b1;
        a_alloc_en = 1'b1;
        a_free_en  = 1'b0;
        a_free_id  = 3'd0;
        b_alloc_en = 1'b0;
        b_free_en  = 1'b0;
        b_free_id  = 3'd0;
        step();
        step();

        // Reset state, with an alloc request that must be ignored
        check_val("rst_avail", {31'd0, a_avail}, 32'd0);
        check_val("rst_id",    {29'd0, a_id},    32'd0);
        check_val("rst_busy",  {24'd0, a_busy},  32'd0);
        check_val("rst_cnt",   {28'd0, a_cnt},   32'd0);
        check_val("rst_err",   {31'd0, a_err},   32'd0);

        // Allocate to full
        areset = 1'b0;
        #1;
        check_val("post_rst_avail", {31'd0, a_avail}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_val("fill_id", {29'd0, a_id}, 32'(i));
            step();
        end
        check_val("full_cnt",   {28'd0, a_cnt},   32'd8);
        check_val("full_busy",  {24'd0, a_busy},  32'hFF);
        check_val("full_avail", {31'd0, a_avail}, 32'd0);
        check_val("full_err",   {31'd0, a_err},   32'd0);
        step();
        check_val("ovf_err", {31'd0, a_err}, 32'd1);
        check_val("ovf_cnt", {28'd0, a_cnt}, 32'd8);

        // Free while full: the pointer has wrapped to 0
        a_alloc_en = 1'b0;
        a_free_en  = 1'b1;
        a_free_id  = 3'd3;
        step();
        a_free_en = 1'b0;
        check_val("ff_avail", {31'd0, a_avail}, 32'd1);
        check_val("ff_id",    {29'd0, a_id},    32'd3);
        check_val("ff_cnt",   {28'd0, a_cnt},   32'd7);

        // Round-robin order
        do_reset();
        a_alloc_en = 1'b1;
        step();
        a_alloc_en = 1'b0;
        a_free_en  = 1'b1;
        a_free_id  = 3'd0;
        step();
        a_free_en = 1'b0;
        step();
        check_val("rr_id", {29'd0, a_id}, 32'd1);
        a_alloc_en = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check_val("rr_seq", {29'd0, a_id}, 32'(i));
            step();
        end
        a_alloc_en = 1'b0;
        check_val("rr_wrap_id", {29'd0, a_id},  32'd0);
        check_val("rr_cnt",     {28'd0, a_cnt}, 32'd7);

        // Simultaneous alloc and free with busy=02, ptr=4
        do_reset();
        a_alloc_en = 1'b1;
        repeat (4) step();
        a_alloc_en = 1'b0;
        a_free_en  = 1'b1;
        a_free_id  = 3'd0; step();
        a_free_id  = 3'd2; step();
        a_free_id  = 3'd3; step();
        a_free_en  = 1'b0;
        check_val("sim_pre_busy", {24'd0, a_busy}, 32'h02);
        check_val("sim_pre_id",   {29'd0, a_id},   32'd4);
        a_alloc_en = 1'b1;
        a_free_en  = 1'b1;
        a_free_id  = 3'd1;
        step();
        a_alloc_en = 1'b0;
        a_free_en  = 1'b0;
        check_val("sim_busy", {24'd0, a_busy}, 32'h10);
        check_val("sim_cnt",  {28'd0, a_cnt},  32'd1);
        check_val("sim_err",  {31'd0, a_err},  32'd0);

        // Double free of idle ID 5
        a_free_en = 1'b1;
        a_free_id = 3'd5;
        step();
        a_free_en = 1'b0;
        check_val("dbl_err",  {31'd0, a_err},  32'd1);
        check_val("dbl_busy", {24'd0, a_busy}, 32'h10);
        check_val("dbl_cnt",  {28'd0, a_cnt},  32'd1);

        // Freeing the ID being allocated in the same cycle is a double free
        do_reset();
        a_alloc_en = 1'b1;
        a_free_en  = 1'b1;
        a_free_id  = 3'd0;
        step();
        a_alloc_en = 1'b0;
        a_free_en  = 1'b0;
        check_val("same_busy", {24'd0, a_busy}, 32'h01);
        check_val("same_cnt",  {28'd0, a_cnt},  32'd1);
        check_val("same_err",  {31'd0, a_err},  32'd1);

        // Reset mid-operation with cnt=6, err set and alloc_en high
        do_reset();
        a_alloc_en = 1'b1;
        a_free_en  = 1'b1;
        a_free_id  = 3'd7;
        step();
        a_free_en = 1'b0;
        repeat (5) step();
        check_val("mid_cnt", {28'd0, a_cnt}, 32'd6);
        check_val("mid_err", {31'd0, a_err}, 32'd1);
        areset = 1'b1;
        #1;
        check_val("mid_rst_avail", {31'd0, a_avail}, 32'd0);
        step();
        areset     = 1'b0;
        a_alloc_en = 1'b0;
        #1;
        check_val("mid_busy",  {24'd0, a_busy},  32'd0);
        check_val("mid_cnt0",  {28'd0, a_cnt},   32'd0);
        check_val("mid_err0",  {31'd0, a_err},   32'd0);
        check_val("mid_id",    {29'd0, a_id},    32'd0);
        check_val("mid_avail", {31'd0, a_avail}, 32'd1);

        // N=5: fill, out-of-range free, pointer wrap
        do_reset();
        b_alloc_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val("n5_fill_id", {29'd0, b_id}, 32'(i));
            step();
        end
        b_alloc_en = 1'b0;
        check_val("n5_full_cnt",   {28'd0, b_cnt},   32'd5);
        check_val("n5_full_busy",  {27'd0, b_busy},  32'h1F);
        check_val("n5_full_avail", {31'd0, b_avail}, 32'd0);
        check_val("n5_full_id",    {29'd0, b_id},    32'd0);
        b_free_en = 1'b1;
        b_free_id = 3'd6;
        step();
        b_free_en = 1'b0;
        check_val("n5_oor_err",  {31'd0, b_err},  32'd1);
        check_val("n5_oor_busy", {27'd0, b_busy}, 32'h1F);
        check_val("n5_oor_cnt",  {28'd0, b_cnt},  32'd5);
        b_free_en = 1'b1;
        b_free_id = 3'd2;
        step();
        b_free_en = 1'b0;
        check_val("n5_wrap_id", {29'd0, b_id}, 32'd2);
        check_val("n5_cnt4",    {28'd0, b_cnt}, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/atcaxi2tluh500_srcid_alloc.md
# atcaxi2tluh500_srcid_alloc

Source-ID allocator for the AXI-to-TL-UH bridge. It tracks which TileLink source IDs are outstanding and hands out a free ID, round-robin, for each new A-channel request. Each allocated ID is released when its D-channel response retires. It sits directly upstream of `atcaxi2tluh500_bin2onehot`: its binary IDs are converted to one-hot set/clear masks for the occupancy vector.

## Interface
- `N`, default 8: number of source IDs, must be ≥ 2; need not be a power of two.
- `W`, localparam `$clog2(N)`: ID width.

- `aclk` in 1: clock; all state changes on its rising edge.
- `areset` in 1: synchronous, active-high reset.
- `alloc_avail` out 1: at least one ID is free and the block is not in reset.
- `alloc_id` out W: ID that will be taken if `alloc_en` is asserted this cycle.
- `alloc_en` in 1: consume `alloc_id` this cycle.
- `free_en` in 1: release `free_id` this cycle.
- `free_id` in W: ID being released.
- `busy` out N: occupancy vector; bit k set means ID k is outstanding.
- `cnt` out W+1: number of outstanding IDs, range 0..N.
- `err` out 1: sticky protocol-error flag, cleared only by reset.

## Operation
- **State registers**
  - `busy[N-1:0]`
  - `ptr[W-1:0]`, the round-robin start position
  - `cnt[W:0]`
  - `err`
- **Reset** (`areset` = 1 at an edge):
  - `busy` = 0, `ptr` = 0, `cnt` = 0, `err` = 0.
  - `alloc_avail` is forced to 0 combinationally while `areset` is high.
  - This applies mid-operation too: all outstanding IDs are dropped and any `alloc_en`/`free_en` in that cycle is ignored.
- **ID selection** (combinational from registers only):
  - `alloc_id` is the first index i with `busy[i]` = 0, searching `ptr`, `ptr+1`, …, `N-1`, `0`, …, `ptr-1`.
  - When no ID is free, `alloc_avail` = 0 and `alloc_id` = 0.
- **Allocate**: `alloc_en` and `alloc_avail`.
  - Set `busy[alloc_id]`.
  - `ptr` ← `alloc_id`+1, wrapping from N-1 to 0. This wrap is explicit compare-to-N-1, not a power-of-two mask.
  - `cnt` increments.
- **Free**: `free_en`, with `free_id` < N and `busy[free_id]` = 1.
  - Clear `busy[free_id]`.
  - `cnt` decrements.
- **Simultaneous valid alloc and free** (necessarily different IDs): both apply, and `cnt` is unchanged.
- **Errors**: each of the following sets `err` and changes no other state.
  - `alloc_en` with `alloc_avail` = 0 (alloc while full).
  - `free_en` with `free_id` ≥ N.
  - `free_en` of an ID whose `busy` bit is 0 (double free). This includes `free_id` == `alloc_id` in the same cycle.
  - If an erroneous free coincides with a valid alloc, the alloc still applies.
- **No bypass**: an ID freed in cycle t becomes selectable from cycle t+1.
- **Occupancy masks**: set and clear masks for `busy` come from two `atcaxi2tluh500_bin2onehot` instances, gated by the enable and validity conditions above.

## Timing
- **Combinational outputs**: `alloc_id` and `alloc_avail` depend on registered state only, plus `areset` for the forced-0 gating. There is no combinational path from `alloc_en`, `free_en` or `free_id` to any output.
- **Registered outputs**: `busy`, `cnt` and `err` reflect an alloc, free or error one cycle after the enabling edge.
- **Throughput**: one alloc and one free per cycle, sustained.
- **Capacity limits**:
  - Full (`cnt` = N) implies `alloc_avail` = 0.
  - Empty (`cnt` = 0) implies `alloc_id` = `ptr`.
- **Reset values**: `alloc_avail` 0 while in reset, 1 in the first cycle after; `alloc_id` 0; `busy` 0; `cnt` 0; `err` 0.

## Structure
- **Shared package** `atcaxi2tluh500_pkg`: add the source-ID count constant (default 8) and the `srcid_t` typedef of width `$clog2(N)`. The bridge's A-channel and D-channel logic use the same type.
- **Sub-module**: `atcaxi2tluh500_bin2onehot`, instantiated twice (set mask and clear mask).
- **Priority search**: a rotate-then-find-first-zero function stays local to this block; no further sub-module.

## Test plan
- **Reset, then allocate to full**: reset, then `alloc_en` held for 8 cycles (N=8).
  - `alloc_id` sequence is 0..7, then `cnt` = 8, `busy` = 8'hFF, `alloc_avail` = 0, `err` = 0.
  - A ninth `alloc_en` sets `err` and leaves `cnt` = 8.
- **Free while full**: from full with `ptr` = 0, free ID 3.
  - Next cycle: `alloc_avail` = 1, `alloc_id` = 3, `cnt` = 7.
- **Round-robin order**: allocate 0, free 0, wait one cycle.
  - `alloc_id` = 1, not 0.
  - After allocating 1..7, `ptr` wraps and `alloc_id` = 0.
- **Simultaneous alloc and free**: `busy` = 8'h02, `ptr` = 4; alloc (id 4) and free id 1 in the same cycle.
  - `busy` = 8'h10, `cnt` = 1.
- **Invalid frees**: double free of idle ID 5; with N=5, `free_id` = 6.
  - Each sets `err`; `busy` and `cnt` are unchanged.
  - With N=5, `ptr` wraps 4→0.
- **Reset mid-operation**: `areset` asserted with `cnt` = 6 and `alloc_en` high.
  - `alloc_avail` = 0 during reset.
  - Next cycle `busy` = 0, `cnt` = 0, `err` = 0; first `alloc_id` after reset is 0.
